gate_response_checker: RTL and testbench
========================================

Name: gate_response_checker

Overview:
- Self-checking response side for the small combinational gate library.
- On `start`, walks all 2^N_INPUTS input vectors on `stim_out` and waits SETTLE_CYCLES per vector.
- Samples the gate-under-test output `dut_y` and compares it against the truth table in EXPECTED.
- Reports pass, mismatch count and first failing vector. Synthesizable, so it serves as the on-chip/BIST partner to each gate.

Parameters:
- N_INPUTS, 2, number of gate inputs; legal 1..4.
- SETTLE_CYCLES, 2, cycles each vector is held before sampling; legal 1..15.
- EXPECTED, 4'b0111 (NAND), truth table of width 2^N_INPUTS; bit k = required `dut_y` for input vector k.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request a full sweep; sampled only in IDLE or DONE.
- dut_y  input  1  output of gate under test.
- stim_out  output  N_INPUTS  current input vector to the gate under test.
- busy  output  1  high while in DRIVE or SAMPLE.
- done  output  1  high while in DONE; holds until next start or reset.
- pass  output  1  done && fail_count==0.
- fail_count  output  N_INPUTS+1  number of mismatching vectors in the last sweep.
- first_fail_vec  output  N_INPUTS  vector of the first mismatch; valid when first_fail_valid.
- first_fail_valid  output  1  at least one mismatch recorded this sweep.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low, port names clk and rst_n.
- Reset values: state=IDLE, all outputs 0.
- Reset priority: reset mid-sweep returns to IDLE on the same edge and discards the sweep.
- States: IDLE, DRIVE, SAMPLE, DONE. All outputs are registered.
- IDLE/DONE with start=1:
  - Next state DRIVE.
  - stim_out=0, settle counter=0.
  - fail_count=0, first_fail_valid=0, first_fail_vec=0, done=0.
- IDLE/DONE with start=0: stay.
- DRIVE: settle counter increments each cycle; when counter==SETTLE_CYCLES-1, go to SAMPLE. DRIVE therefore lasts exactly SETTLE_CYCLES cycles.
- SAMPLE (one cycle): at the exiting edge, compare dut_y with EXPECTED[stim_out].
  - On mismatch, fail_count+=1.
  - If first_fail_valid==0, also set first_fail_vec=stim_out and first_fail_valid=1.
  - If stim_out == all ones, next state DONE and stim_out holds its last value.
  - Otherwise stim_out+=1, counter=0, next state DRIVE.
- stim_out is stable throughout DRIVE and SAMPLE of a vector; it changes only on the SAMPLE exit edge.
- Latency: done rises 2^N_INPUTS*(SETTLE_CYCLES+1) edges after the edge that accepted start. Default configuration: 12 cycles.
- start while busy=1: ignored, no effect on the sweep.
- start held high continuously: a new sweep restarts on the edge after entering DONE, so done is high for exactly one cycle.
- fail_count cannot overflow: its maximum is 2^N_INPUTS, which fits in N_INPUTS+1 bits.
- pass is 0 outside DONE.
- first_fail_vec and fail_count persist in DONE until the next start.

Test Plan:
1. Default params, dut_y driven by a correct NAND of stim_out[1:0], pulse start → busy for 12 cycles, stim_out steps 00,01,10,11, then done=1, pass=1, fail_count=0, first_fail_valid=0.
2. Default params, dut_y stuck at 0 → done after 12 cycles, pass=0, fail_count=3, first_fail_vec=00, first_fail_valid=1.
3. Default params, dut_y driven by AND (inverted function) → fail_count=4, first_fail_vec=00, pass=0. Then swap in a correct NAND and pulse start from DONE → counters cleared on accept, second sweep ends pass=1, fail_count=0.
4. Pulse start, assert rst_n=0 for one cycle at cycle 5 → next edge: IDLE, stim_out=0, busy=0, done=0. With no further start, stays IDLE for 20 cycles.
5. Pulse start again at cycles 3 and 7 of a sweep → ignored; done still rises exactly 12 cycles after the first accept, and each vector holds 3 cycles.
6. N_INPUTS=3, SETTLE_CYCLES=1, EXPECTED=8'h7F, correct 3-input NAND → stim_out steps 0..7 two cycles each, done after 16 cycles, pass=1. Same setup with dut_y forced 1 when stim_out=7 → fail_count=1, first_fail_vec=3'b111.

Source files
------------

// File: rtl/gate_response_checker.sv
// Response-side checker for the combinational gate library: sweeps every
// input vector onto the gate under test, lets it settle, samples its output
// and compares it with the expected truth table. Reports pass/fail, the
// number of mismatching vectors and the first vector that mismatched.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | after reset, waiting for start
// DRIVE  | holding stim_out for SETTLE_CYCLES cycles while the gate settles
// SAMPLE | one cycle: compare dut_y, then step to next vector or finish
// DONE   | sweep complete, results held until the next start
module gate_response_checker #(
   parameter int                          N_INPUTS      = 2,
   parameter int                          SETTLE_CYCLES = 2,
   parameter logic [(1<<N_INPUTS)-1:0]    EXPECTED      = 4'b0111
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  dut_y,
   output logic [N_INPUTS-1:0]   stim_out,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [N_INPUTS:0]     fail_count,
   output logic [N_INPUTS-1:0]   first_fail_vec,
   output logic                  first_fail_valid
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DRIVE  = 2'd1;
   localparam logic [1:0] ST_SAMPLE = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   localparam logic [N_INPUTS-1:0] LAST_VEC    = '1;
   localparam logic [3:0]          SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   logic [1:0]          state;
   logic [3:0]          settle_cnt;
   logic                mismatch;
   logic [N_INPUTS:0]   fail_next;

   // Compare the settled gate output with the truth-table bit for this vector.
   always_comb begin
      mismatch  = (dut_y != EXPECTED[stim_out]);
      fail_next = fail_count + {{N_INPUTS{1'b0}}, mismatch};
   end

   // Sweep sequencer; every output is a register updated here.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state            <= ST_IDLE;
         settle_cnt       <= '0;
         stim_out         <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         pass             <= 1'b0;
         fail_count       <= '0;
         first_fail_vec   <= '0;
         first_fail_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state            <= ST_DRIVE;
                  settle_cnt       <= '0;
                  stim_out         <= '0;
                  busy             <= 1'b1;
                  done             <= 1'b0;
                  pass             <= 1'b0;
                  fail_count       <= '0;
                  first_fail_vec   <= '0;
                  first_fail_valid <= 1'b0;
               end
            end
            ST_DRIVE: begin
               if (settle_cnt == SETTLE_LAST) begin
                  state <= ST_SAMPLE;
               end else begin
                  settle_cnt <= settle_cnt + 4'd1;
               end
            end
            ST_SAMPLE: begin
               fail_count <= fail_next;
               if (mismatch && !first_fail_valid) begin
                  first_fail_vec   <= stim_out;
                  first_fail_valid <= 1'b1;
               end
               if (stim_out == LAST_VEC) begin
                  // stim_out keeps the last vector while results are held
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (fail_next == '0);
               end else begin
                  state      <= ST_DRIVE;
                  stim_out   <= stim_out + 1'b1;
                  settle_cnt <= '0;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gate_response_checker.sv
// Bench for gate_response_checker: a 2-input NAND checker (defaults) and a
// 3-input NAND checker with one-cycle settle, each driven by a table-lookup
// model gate whose truth table the bench chooses per sweep.
module tb_gate_response_checker;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_a = 1'b0;
   logic        start_b = 1'b0;
   logic [15:0] tt_a = 16'h0007;
   logic [15:0] tt_b = 16'h007F;

   logic        dut_y_a, dut_y_b;
   logic [1:0]  stim_a, ffv_a;
   logic [2:0]  fc_a;
   logic        busy_a, done_a, pass_a, ffvalid_a;
   logic [2:0]  stim_b, ffv_b;
   logic [3:0]  fc_b;
   logic        busy_b, done_b, pass_b, ffvalid_b;

   int checks = 0;
   int errors = 0;

   // observations of the most recent sweep, index = edges after the accept
   int obs_stim [0:47];
   bit obs_busy [0:47];
   int done_edge;
   int fc0, ffvalid0, done0;

   assign dut_y_a = tt_a[stim_a];
   assign dut_y_b = tt_b[stim_b];

   always #5 clk = ~clk;

   gate_response_checker u_dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .dut_y(dut_y_a),
      .stim_out(stim_a), .busy(busy_a), .done(done_a), .pass(pass_a),
      .fail_count(fc_a), .first_fail_vec(ffv_a), .first_fail_valid(ffvalid_a)
   );

   gate_response_checker #(.N_INPUTS(3), .SETTLE_CYCLES(1), .EXPECTED(8'h7F)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .dut_y(dut_y_b),
      .stim_out(stim_b), .busy(busy_b), .done(done_b), .pass(pass_b),
      .fail_count(fc_b), .first_fail_vec(ffv_b), .first_fail_valid(ffvalid_b)
   );

   // Reference: count table disagreements over all 2^n vectors, lowest first.
   function automatic void ref_sweep(input int n, input logic [15:0] exp_tt,
                                     input logic [15:0] gate_tt, output int fc,
                                     output int ffv, output int ffvalid);
      fc = 0; ffv = 0; ffvalid = 0;
      for (int k = 0; k < (1 << n); k++) begin
         if (gate_tt[k] !== exp_tt[k]) begin
            fc++;
            if (ffvalid == 0) begin
               ffv = k;
               ffvalid = 1;
            end
         end
      end
   endfunction

   // Accept a start, then record the sweep edge by edge (bounded).
   // Extra start pulses are raised after edges re1 and re2.
   task automatic do_sweep(input bit sel, input int re1, input int re2);
      @(posedge clk); #1;
      if (sel) start_b = 1'b1; else start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0; start_b = 1'b0;
      done_edge = -1;
      for (int j = 0; j < 48; j++) begin
         obs_stim[j] = sel ? int'(stim_b) : int'(stim_a);
         obs_busy[j] = sel ? busy_b : busy_a;
         if (j == 0) begin
            fc0      = sel ? int'(fc_b) : int'(fc_a);
            ffvalid0 = sel ? int'(ffvalid_b) : int'(ffvalid_a);
            done0    = sel ? int'(done_b) : int'(done_a);
         end
         if (sel ? done_b : done_a) begin
            done_edge = j;
            break;
         end
         if (j == re1 || j == re2) begin
            if (sel) start_b = 1'b1; else start_a = 1'b1;
         end else begin
            start_a = 1'b0; start_b = 1'b0;
         end
         @(posedge clk); #1;
      end
      start_a = 1'b0; start_b = 1'b0;
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({stim_a, busy_a, done_a, pass_a, fc_a, ffv_a, ffvalid_a} !== 12'd0) begin
         errors++;
         $display("FAIL reset_a got %h want 0", {stim_a, busy_a, done_a, pass_a, fc_a, ffv_a, ffvalid_a});
      end
      checks++;
      if ({stim_b, busy_b, done_b, pass_b, fc_b, ffv_b, ffvalid_b} !== 15'd0) begin
         errors++;
         $display("FAIL reset_b got %h want 0", {stim_b, busy_b, done_b, pass_b, fc_b, ffv_b, ffvalid_b});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_nand_pass;
      tt_a = 16'h0007;
      do_sweep(1'b0, -1, -1);
      checks++;
      if (done_edge != 12) begin
         errors++;
         $display("FAIL nand_done_edge got %0d want 12", done_edge);
      end
      for (int j = 0; j < 12; j++) begin
         checks++;
         if (obs_stim[j] != j / 3 || obs_busy[j] !== 1'b1) begin
            errors++;
            $display("FAIL nand_trace edge %0d got stim %0d busy %0b want stim %0d busy 1",
                     j, obs_stim[j], obs_busy[j], j / 3);
         end
      end
      checks++;
      if ({pass_a, busy_a, int'(fc_a), ffvalid_a} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
         errors++;
         $display("FAIL nand_result got pass %0b busy %0b fc %0d ffvalid %0b want 1 0 0 0",
                  pass_a, busy_a, fc_a, ffvalid_a);
      end
   endtask

   task automatic test_stuck0;
      tt_a = 16'h0000;
      do_sweep(1'b0, -1, -1);
      checks++;
      if (done_edge != 12 || pass_a !== 1'b0 || fc_a !== 3'd3 || ffv_a !== 2'd0 || ffvalid_a !== 1'b1) begin
         errors++;
         $display("FAIL stuck0 got edge %0d pass %0b fc %0d ffv %0d ffvalid %0b want 12 0 3 0 1",
                  done_edge, pass_a, fc_a, ffv_a, ffvalid_a);
      end
   endtask

   task automatic test_and_then_restart;
      tt_a = 16'h0008;
      do_sweep(1'b0, -1, -1);
      checks++;
      if (done_edge != 12 || pass_a !== 1'b0 || fc_a !== 3'd4 || ffv_a !== 2'd0 || ffvalid_a !== 1'b1) begin
         errors++;
         $display("FAIL and_gate got edge %0d pass %0b fc %0d ffv %0d ffvalid %0b want 12 0 4 0 1",
                  done_edge, pass_a, fc_a, ffv_a, ffvalid_a);
      end
      tt_a = 16'h0007;
      do_sweep(1'b0, -1, -1);
      checks++;
      if (fc0 != 0 || ffvalid0 != 0 || done0 != 0) begin
         errors++;
         $display("FAIL restart_clear got fc %0d ffvalid %0d done %0d want 0 0 0", fc0, ffvalid0, done0);
      end
      checks++;
      if (done_edge != 12 || pass_a !== 1'b1 || fc_a !== 3'd0) begin
         errors++;
         $display("FAIL restart_result got edge %0d pass %0b fc %0d want 12 1 0", done_edge, pass_a, fc_a);
      end
   endtask

   task automatic test_reset_mid_sweep;
      tt_a = 16'h0000;
      @(posedge clk); #1;
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      checks++;
      if ({stim_a, busy_a, done_a, fc_a} !== 7'd0) begin
         errors++;
         $display("FAIL mid_reset got stim %0d busy %0b done %0b fc %0d want 0 0 0 0",
                  stim_a, busy_a, done_a, fc_a);
      end
      for (int j = 0; j < 20; j++) begin
         @(posedge clk); #1;
         checks++;
         if ({stim_a, busy_a, done_a} !== 4'd0) begin
            errors++;
            $display("FAIL idle_hold cycle %0d got stim %0d busy %0b done %0b want 0 0 0",
                     j, stim_a, busy_a, done_a);
         end
      end
   endtask

   task automatic test_start_while_busy;
      tt_a = 16'h0007;
      do_sweep(1'b0, 3, 7);
      checks++;
      if (done_edge != 12) begin
         errors++;
         $display("FAIL busy_start_done_edge got %0d want 12", done_edge);
      end
      for (int j = 0; j < 12; j++) begin
         checks++;
         if (obs_stim[j] != j / 3) begin
            errors++;
            $display("FAIL busy_start_trace edge %0d got %0d want %0d", j, obs_stim[j], j / 3);
         end
      end
   endtask

   task automatic test_three_input;
      tt_b = 16'h007F;
      do_sweep(1'b1, -1, -1);
      checks++;
      if (done_edge != 16 || pass_b !== 1'b1 || fc_b !== 4'd0) begin
         errors++;
         $display("FAIL nand3 got edge %0d pass %0b fc %0d want 16 1 0", done_edge, pass_b, fc_b);
      end
      for (int j = 0; j < 16; j++) begin
         checks++;
         if (obs_stim[j] != j / 2) begin
            errors++;
            $display("FAIL nand3_trace edge %0d got %0d want %0d", j, obs_stim[j], j / 2);
         end
      end
      tt_b = 16'h00FF;
      do_sweep(1'b1, -1, -1);
      checks++;
      if (pass_b !== 1'b0 || fc_b !== 4'd1 || ffv_b !== 3'd7 || ffvalid_b !== 1'b1) begin
         errors++;
         $display("FAIL nand3_fault7 got pass %0b fc %0d ffv %0d ffvalid %0b want 0 1 7 1",
                  pass_b, fc_b, ffv_b, ffvalid_b);
      end
   endtask

   task automatic test_random;
      int fc, ffv, ffvalid;
      for (int it = 0; it < 12; it++) begin
         bit sel;
         sel = it[0];
         if (sel) tt_b = 16'($urandom_range(0, 255));
         else     tt_a = 16'($urandom_range(0, 15));
         do_sweep(sel, -1, -1);
         if (sel) ref_sweep(3, 16'h007F, tt_b, fc, ffv, ffvalid);
         else     ref_sweep(2, 16'h0007, tt_a, fc, ffv, ffvalid);
         checks++;
         if (done_edge != (sel ? 16 : 12)) begin
            errors++;
            $display("FAIL rand_done_edge it %0d got %0d want %0d", it, done_edge, sel ? 16 : 12);
         end
         checks++;
         if ((sel ? int'(fc_b) : int'(fc_a)) != fc ||
             (sel ? int'(ffv_b) : int'(ffv_a)) != ffv ||
             (sel ? int'(ffvalid_b) : int'(ffvalid_a)) != ffvalid ||
             (sel ? int'(pass_b) : int'(pass_a)) != int'(fc == 0)) begin
            errors++;
            $display("FAIL rand_result it %0d tt %h got fc %0d ffv %0d ffvalid %0d pass %0d want %0d %0d %0d %0d",
                     it, sel ? tt_b : tt_a,
                     sel ? int'(fc_b) : int'(fc_a), sel ? int'(ffv_b) : int'(ffv_a),
                     sel ? int'(ffvalid_b) : int'(ffvalid_a), sel ? int'(pass_b) : int'(pass_a),
                     fc, ffv, ffvalid, int'(fc == 0));
         end
      end
   endtask

   initial begin
      test_reset();
      test_nand_pass();
      test_stuck0();
      test_and_then_restart();
      test_reset_mid_sweep();
      test_start_while_busy();
      test_three_input();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
